// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two cache miss ports, the main-memory port and the status
// outputs of the memory port arbiter. The master view belongs to the arbiter,
// the slave view to its surroundings (caches plus main memory).
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // I-cache miss port
   logic              ic_req;
   logic [ADDR_W-1:0] ic_addr;
   logic              ic_ack;
   logic [DATA_W-1:0] ic_rdata;
   // D-cache miss port
   logic              dc_req;
   logic [ADDR_W-1:0] dc_addr;
   logic              dc_wb;
   logic [ADDR_W-1:0] dc_wb_addr;
   logic [DATA_W-1:0] dc_wb_data;
   logic              dc_ack;
   logic [DATA_W-1:0] dc_rdata;
   // main-memory port
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   // status
   logic              stall;
   logic              timeout_err;

   modport master (
      input  ic_req, ic_addr,
      output ic_ack, ic_rdata,
      input  dc_req, dc_addr, dc_wb, dc_wb_addr, dc_wb_data,
      output dc_ack, dc_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata,
      output stall, timeout_err
   );

   modport slave (
      output ic_req, ic_addr,
      input  ic_ack, ic_rdata,
      output dc_req, dc_addr, dc_wb, dc_wb_addr, dc_wb_data,
      input  dc_ack, dc_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata,
      input  stall, timeout_err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between the I-cache and D-cache miss paths.
// A D-cache miss is an optional dirty-victim write followed by a refill read.
// Ties are broken round-robin; every memory operation is bounded by TIMEOUT
// cycles, after which the operation is abandoned and timeout_err sticks.
// A refill always spends its first cycle with mem_req low; this is also the
// one-cycle gap between a writeback and its refill.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input logic                clk,
   input logic                reset,
   mem_port_arbiter_if.master bus
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WB     = 2'd1,
      REFILL = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t            state_r;
   state_t            next_state_s;

   // transaction context, captured at grant
   logic              owner_dc_r;
   logic              last_grant_dc_r;
   logic              wb_r;
   logic [ADDR_W-1:0] refill_addr_r;
   logic [ADDR_W-1:0] wb_addr_r;
   logic [DATA_W-1:0] wb_data_r;

   logic [CNT_W-1:0]  cnt_r;
   logic              timeout_err_r;

   logic              mem_req_r;
   logic              mem_we_r;
   logic [ADDR_W-1:0] mem_addr_r;
   logic [DATA_W-1:0] mem_wdata_r;
   logic              ic_ack_r;
   logic              dc_ack_r;
   logic [DATA_W-1:0] ic_rdata_r;
   logic [DATA_W-1:0] dc_rdata_r;

   logic              grant_s;
   logic              grant_dc_s;
   logic              owner_src_s;
   logic              wb_src_s;
   logic [ADDR_W-1:0] refill_addr_src_s;
   logic [ADDR_W-1:0] wb_addr_src_s;
   logic [DATA_W-1:0] wb_data_src_s;
   logic              in_mem_s;
   logic              ack_s;
   logic              timeout_hit_s;

   // Arbitration in IDLE and selection of the transaction context source.
   always_comb begin
      grant_s    = 1'b0;
      grant_dc_s = 1'b0;
      if (state_r == IDLE) begin
         if (bus.ic_req && bus.dc_req) begin
            grant_s    = 1'b1;
            grant_dc_s = ~last_grant_dc_r;
         end else if (bus.dc_req) begin
            grant_s    = 1'b1;
            grant_dc_s = 1'b1;
         end else if (bus.ic_req) begin
            grant_s    = 1'b1;
            grant_dc_s = 1'b0;
         end else begin
            grant_s    = 1'b0;
            grant_dc_s = 1'b0;
         end
      end else begin
         grant_s    = 1'b0;
         grant_dc_s = 1'b0;
      end

      owner_src_s       = owner_dc_r;
      wb_src_s          = wb_r;
      refill_addr_src_s = refill_addr_r;
      wb_addr_src_s     = wb_addr_r;
      wb_data_src_s     = wb_data_r;
      if (grant_s) begin
         owner_src_s       = grant_dc_s;
         wb_src_s          = grant_dc_s & bus.dc_wb;
         refill_addr_src_s = grant_dc_s ? bus.dc_addr : bus.ic_addr;
         wb_addr_src_s     = bus.dc_wb_addr;
         wb_data_src_s     = bus.dc_wb_data;
      end else begin
         owner_src_s       = owner_dc_r;
      end

      // a memory ack only counts while this block actually has a request up
      in_mem_s      = (state_r == WB) || (state_r == REFILL);
      ack_s         = in_mem_s & mem_req_r & bus.mem_ack;
      timeout_hit_s = in_mem_s & ~ack_s & (cnt_r == CNT_W'(TIMEOUT - 1));
   end

   // Next-state logic of the miss sequencer.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (grant_s) begin
               next_state_s = wb_src_s ? WB : REFILL;
            end else begin
               next_state_s = IDLE;
            end
         end
         WB: begin
            if (ack_s || timeout_hit_s) begin
               next_state_s = REFILL;
            end else begin
               next_state_s = WB;
            end
         end
         REFILL: begin
            if (ack_s || timeout_hit_s) begin
               next_state_s = RESP;
            end else begin
               next_state_s = REFILL;
            end
         end
         RESP:    next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Capture owner, addresses and victim data at grant; track the last winner.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_dc_r      <= 1'b0;
         last_grant_dc_r <= 1'b0;
         wb_r            <= 1'b0;
         refill_addr_r   <= {ADDR_W{1'b0}};
         wb_addr_r       <= {ADDR_W{1'b0}};
         wb_data_r       <= {DATA_W{1'b0}};
      end else if (grant_s) begin
         owner_dc_r      <= owner_src_s;
         last_grant_dc_r <= grant_dc_s;
         wb_r            <= wb_src_s;
         refill_addr_r   <= refill_addr_src_s;
         wb_addr_r       <= wb_addr_src_s;
         wb_data_r       <= wb_data_src_s;
      end
   end

   // Per-state wait counter and sticky timeout flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r         <= {CNT_W{1'b0}};
         timeout_err_r <= 1'b0;
      end else begin
         if (next_state_s != state_r) begin
            cnt_r <= {CNT_W{1'b0}};
         end else if (in_mem_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
         end else begin
            cnt_r <= {CNT_W{1'b0}};
         end
         if (timeout_hit_s) begin
            timeout_err_r <= 1'b1;
         end
      end
   end

   // Registered memory-side outputs; a refill's first cycle keeps mem_req low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= {ADDR_W{1'b0}};
         mem_wdata_r <= {DATA_W{1'b0}};
      end else begin
         mem_req_r <= (next_state_s == WB) ||
                      ((state_r == REFILL) && (next_state_s == REFILL));
         mem_we_r  <= (next_state_s == WB);
         if (next_state_s == WB) begin
            mem_addr_r  <= wb_addr_src_s;
            mem_wdata_r <= wb_data_src_s;
         end else if (next_state_s == REFILL) begin
            mem_addr_r  <= refill_addr_src_s;
         end
      end
   end

   // Registered acks and per-port refill data; an abandoned refill returns 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ic_ack_r   <= 1'b0;
         dc_ack_r   <= 1'b0;
         ic_rdata_r <= {DATA_W{1'b0}};
         dc_rdata_r <= {DATA_W{1'b0}};
      end else begin
         ic_ack_r <= (next_state_s == RESP) && !owner_dc_r;
         dc_ack_r <= (next_state_s == RESP) &&  owner_dc_r;
         if ((state_r == REFILL) && (next_state_s == RESP)) begin
            if (owner_dc_r) begin
               dc_rdata_r <= ack_s ? bus.mem_rdata : {DATA_W{1'b0}};
            end else begin
               ic_rdata_r <= ack_s ? bus.mem_rdata : {DATA_W{1'b0}};
            end
         end
      end
   end

   assign bus.mem_req     = mem_req_r;
   assign bus.mem_we      = mem_we_r;
   assign bus.mem_addr    = mem_addr_r;
   assign bus.mem_wdata   = mem_wdata_r;
   assign bus.ic_ack      = ic_ack_r;
   assign bus.dc_ack      = dc_ack_r;
   assign bus.ic_rdata    = ic_rdata_r;
   assign bus.dc_rdata    = dc_rdata_r;
   assign bus.timeout_err = timeout_err_r;
   assign bus.stall       = (state_r != IDLE) || bus.ic_req || bus.dc_req;
endmodule
